// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: advances one of four LED patterns on each enabled
// rising edge of an upstream divided-clock level.
module led_pattern_sequencer #(
  parameter int unsigned LED_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  output logic [LED_W-1:0] led_o,
  output logic             step_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] LED_ONES = {LED_W{1'b1}};

  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             step_ev;
  mode_e            mode_in;

  assign mode_in = mode_e'(mode_i);
  assign step_ev = tick_i & ~tick_q & en_i;

  // Next-state: a mode change reloads the pattern and wins over a coincident step.
  always_comb begin
    led_d  = led_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    mode_d = mode_q;
    dir_d  = dir_q;
    tick_d = tick_i;

    if (mode_in != mode_q) begin
      mode_d = mode_in;
      dir_d  = DIR_UP;
      unique case (mode_in)
        MODE_SHIFT, MODE_BOUNCE: led_d = LED_ONE;
        default:                 led_d = '0;
      endcase
    end else if (step_ev) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_BLINK: begin
          led_d  = ~led_q;
          wrap_d = (led_q == LED_ONES);
        end
        MODE_SHIFT: begin
          led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
          wrap_d = led_q[LED_W-1];
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            led_d = led_q << 1;
            if (led_d[LED_W-1]) dir_d = DIR_DOWN;
          end else begin
            led_d = led_q >> 1;
            if (led_d[0]) begin
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end
          end
        end
        default: begin
          led_d  = led_q + LED_ONE;
          wrap_d = (led_q == LED_ONES);
        end
      endcase
    end
  end

  // State register; tick_q resets high so a tick already high at release is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      mode_q <= MODE_BLINK;
      dir_q  <= DIR_UP;
      tick_q <= 1'b1;
    end else begin
      led_q  <= led_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  assign led_o  = led_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: two widths (8 and 4) driven in parallel,
// checked against a position-counter reference model plus a hand-written table.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] led8;
  logic [3:0] led4;
  logic       step8, wrap8, step4, wrap4;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.LED_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .mode_i(mode),
    .led_o(led8), .step_o(step8), .wrap_o(wrap8)
  );

  led_pattern_sequencer #(.LED_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .mode_i(mode),
    .led_o(led4), .step_o(step4), .wrap_o(wrap4)
  );

  typedef struct {
    logic [31:0] led;
    logic        step;
    logic        wrap;
  } exp_t;

  typedef struct {
    logic       r;
    logic       t;
    logic       e;
    logic [1:0] m;
    logic [7:0] led;
    logic       step;
    logic       wrap;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: pattern position counter per instance (0 -> width 8, 1 -> width 4)
  int     m_w[2]    = '{8, 4};
  int     m_mode[2] = '{0, 0};
  longint m_cnt[2]  = '{0, 0};
  bit     m_tq[2]   = '{1'b1, 1'b1};

  // observed-output tallies used by the sequence checks
  int steps8, wraps8, steps4, wraps4, nonhot8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint period_of(input int md, input int w);
    case (md)
      0:       return 2;
      1:       return longint'(w);
      2:       return longint'(2 * (w - 1));
      default: return longint'(1) << w;
    endcase
  endfunction

  function automatic logic [31:0] led_of(input int md, input longint c, input int w);
    longint mask;
    longint p;
    mask = (longint'(1) << w) - 1;
    p    = longint'(2 * (w - 1));
    case (md)
      0:       return (c % 2 == 1) ? 32'(mask) : 32'd0;
      1:       return 32'(longint'(1) << c);
      2:       return 32'(longint'(1) << ((c <= longint'(w - 1)) ? c : p - c));
      default: return 32'(c & mask);
    endcase
  endfunction

  task automatic model(input int k, input logic r, input logic t, input logic e,
                       input logic [1:0] m, output exp_t x);
    x.step = 1'b0;
    x.wrap = 1'b0;
    if (r) begin
      m_mode[k] = 0;
      m_cnt[k]  = 0;
      m_tq[k]   = 1'b1;
    end else begin
      if (int'(m) != m_mode[k]) begin
        m_mode[k] = int'(m);
        m_cnt[k]  = 0;
      end else if (t && !m_tq[k] && e) begin
        m_cnt[k] = (m_cnt[k] + 1) % period_of(m_mode[k], m_w[k]);
        x.step   = 1'b1;
        x.wrap   = (m_cnt[k] == 0);
      end
      m_tq[k] = t;
    end
    x.led = led_of(m_mode[k], m_cnt[k], m_w[k]);
  endtask

  // one clock: drive, push model expectations, then pop and compare after the edge
  task automatic apply(input logic r, input logic t, input logic e, input logic [1:0] m);
    exp_t x8, x4, g8, g4;
    rst = r; tick = t; en = e; mode = m;
    model(0, r, t, e, m, x8);
    model(1, r, t, e, m, x4);
    q8.push_back(x8);
    q4.push_back(x4);
    @(posedge clk);
    #1;
    if (q8.size() == 0 || q4.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      g8 = q8.pop_front();
      g4 = q4.pop_front();
      chk("led8", 32'(led8), g8.led);
      chk("step8", 32'(step8), 32'(g8.step));
      chk("wrap8", 32'(wrap8), 32'(g8.wrap));
      chk("led4", 32'(led4), g4.led);
      chk("step4", 32'(step4), 32'(g4.step));
      chk("wrap4", 32'(wrap4), 32'(g4.wrap));
    end
    if (step8) steps8++;
    if (wrap8) wraps8++;
    if (step4) steps4++;
    if (wrap4) wraps4++;
    if (!$onehot(led8)) nonhot8++;
  endtask

  task automatic tick_edge(input logic [1:0] m);
    apply(1'b0, 1'b0, 1'b1, m);
    apply(1'b0, 1'b1, 1'b1, m);
  endtask

  task automatic clear_tallies();
    steps8 = 0; wraps8 = 0; steps4 = 0; wraps4 = 0; nonhot8 = 0;
  endtask

  task automatic add(input logic r, input logic t, input logic e, input logic [1:0] m,
                     input logic [7:0] led, input logic s, input logic w);
    vec_t v;
    v.r = r; v.t = t; v.e = e; v.m = m; v.led = led; v.step = s; v.wrap = w;
    vecs.push_back(v);
  endtask

  initial begin
    // r  t  e  mode   led    step wrap
    add(1, 0, 0, 2'd0, 8'h00, 0, 0);
    add(0, 0, 1, 2'd0, 8'h00, 0, 0);
    add(0, 1, 1, 2'd0, 8'hFF, 1, 0);
    add(0, 0, 1, 2'd0, 8'hFF, 0, 0);
    add(0, 1, 1, 2'd0, 8'h00, 1, 1);
    add(0, 0, 1, 2'd3, 8'h00, 0, 0);
    add(0, 1, 1, 2'd3, 8'h01, 1, 0);
    add(0, 0, 1, 2'd3, 8'h01, 0, 0);
    add(0, 1, 1, 2'd3, 8'h02, 1, 0);
    add(0, 0, 1, 2'd3, 8'h02, 0, 0);
    add(0, 1, 1, 2'd3, 8'h03, 1, 0);
    add(0, 0, 1, 2'd3, 8'h03, 0, 0);
    add(0, 1, 1, 2'd3, 8'h04, 1, 0);
    add(0, 0, 0, 2'd3, 8'h04, 0, 0);
    add(0, 1, 0, 2'd3, 8'h04, 0, 0);
    add(0, 0, 0, 2'd3, 8'h04, 0, 0);
    add(0, 1, 0, 2'd3, 8'h04, 0, 0);
    add(0, 0, 0, 2'd3, 8'h04, 0, 0);
    add(0, 1, 0, 2'd3, 8'h04, 0, 0);
    add(0, 1, 1, 2'd3, 8'h04, 0, 0);
    add(0, 1, 1, 2'd3, 8'h04, 0, 0);
    add(0, 0, 1, 2'd3, 8'h04, 0, 0);
    add(0, 1, 1, 2'd3, 8'h05, 1, 0);
    add(0, 0, 1, 2'd3, 8'h05, 0, 0);
    add(0, 1, 1, 2'd1, 8'h01, 0, 0);
    add(0, 0, 1, 2'd1, 8'h01, 0, 0);
    add(0, 1, 1, 2'd1, 8'h02, 1, 0);

    clear_tallies();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].t, vecs[i].e, vecs[i].m);
      chk($sformatf("tbl%0d_led", i), 32'(led8), 32'(vecs[i].led));
      chk($sformatf("tbl%0d_step", i), 32'(step8), 32'(vecs[i].step));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap8), 32'(vecs[i].wrap));
    end

    // SHIFT from reset, 9 tick edges
    apply(1'b1, 1'b0, 1'b1, 2'd1);
    apply(1'b0, 1'b0, 1'b1, 2'd1);
    chk("shift_init", 32'(led8), 32'h01);
    clear_tallies();
    for (int i = 0; i < 9; i++) begin
      tick_edge(2'd1);
      if (i == 7) chk("shift_wrap_step", 32'({wrap8, led8}), 32'h101);
    end
    chk("shift_steps", 32'(steps8), 32'd9);
    chk("shift_wraps", 32'(wraps8), 32'd1);

    // BOUNCE, 15 tick edges
    apply(1'b0, 1'b0, 1'b1, 2'd2);
    chk("bounce_init", 32'(led8), 32'h01);
    clear_tallies();
    for (int i = 0; i < 15; i++) begin
      tick_edge(2'd2);
      if (i == 6)  chk("bounce_top", 32'(led8), 32'h80);
      if (i == 13) chk("bounce_wrap14", 32'({wrap8, led8}), 32'h101);
    end
    chk("bounce_end", 32'(led8), 32'h02);
    chk("bounce_wraps", 32'(wraps8), 32'd1);
    chk("bounce_onehot", 32'(nonhot8), 32'd0);

    // COUNT, 17 tick edges (width 4 wraps once)
    apply(1'b0, 1'b0, 1'b1, 2'd3);
    clear_tallies();
    for (int i = 0; i < 17; i++) begin
      tick_edge(2'd3);
      if (i == 15) chk("count_wrap_step", 32'({wrap4, led4}), 32'h10);
    end
    chk("count_end4", 32'(led4), 32'h1);
    chk("count_wraps4", 32'(wraps4), 32'd1);
    chk("count_steps4", 32'(steps4), 32'd17);

    // reset while BOUNCE sits at 80 heading down, tick held high across release
    apply(1'b0, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 7; i++) tick_edge(2'd2);
    chk("pre_rst_led", 32'(led8), 32'h80);
    apply(1'b1, 1'b1, 1'b1, 2'd2);
    chk("rst_led", 32'(led8), 32'h00);
    chk("rst_pulses", 32'({step8, wrap8, step4, wrap4}), 32'd0);
    clear_tallies();
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, 2'd2);
    chk("post_rst_nostep", 32'(steps8 + wraps8 + steps4 + wraps4), 32'd0);
    chk("post_rst_led", 32'(led8), 32'h01);
    tick_edge(2'd2);
    chk("post_rst_step", 32'(steps8), 32'd1);
    chk("post_rst_led2", 32'(led8), 32'h02);

    // BLINK at both widths
    apply(1'b0, 1'b0, 1'b1, 2'd0);
    clear_tallies();
    for (int i = 0; i < 4; i++) tick_edge(2'd0);
    chk("blink_wraps", 32'(wraps8 + wraps4), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
